// File: rtl/nm_host_sequencer_if.sv
// Bundle of the command, component, result and neuron-network bus signals
// around nm_host_sequencer; master is the sequencer side, slave the system/network side.
interface nm_host_sequencer_if #(
    parameter int LEN_W = 9
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [LEN_W-1:0] cmd_len;
    logic [14:0]      cmd_cat;

    logic             comp_valid;
    logic             comp_ready;
    logic [7:0]       comp_data;

    logic             res_valid;
    logic             res_err;
    logic [15:0]      res_dist;
    logic [15:0]      res_cat;
    logic [15:0]      res_nid;

    logic             nm_cs_l;
    logic             nm_ds;
    logic             nm_rw_l;
    logic [3:0]       nm_reg;
    logic [15:0]      nm_wdata;
    logic             nm_data_oe;
    logic [15:0]      nm_rdata;
    logic             nm_rdy;

    // Handshakes: a command transfers on a cycle with cmd_valid & cmd_ready, a
    // component on a cycle with comp_valid & comp_ready; res_valid is a one-cycle
    // pulse that needs no acknowledge, and res_err is meaningful only with it.
    modport master (
        input  cmd_valid, cmd_op, cmd_len, cmd_cat,
        output cmd_ready,
        input  comp_valid, comp_data,
        output comp_ready,
        output res_valid, res_err, res_dist, res_cat, res_nid,
        output nm_cs_l, nm_ds, nm_rw_l, nm_reg, nm_wdata, nm_data_oe,
        input  nm_rdata, nm_rdy
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_len, cmd_cat,
        input  cmd_ready,
        output comp_valid, comp_data,
        input  comp_ready,
        input  res_valid, res_err, res_dist, res_cat, res_nid,
        input  nm_cs_l, nm_ds, nm_rw_l, nm_reg, nm_wdata, nm_data_oe,
        output nm_rdata, nm_rdy
    );
endinterface

// File: rtl/nm_host_sequencer.sv
// Single bus master for the neuron network: turns one LEARN/RECOGNIZE/FORGET
// command plus its component stream into the register access sequence.
module nm_host_sequencer #(
    parameter int MAX_LEN = 256,
    parameter int TIMEOUT = 4096,
    parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic                G_CLK,
    input  logic                G_RESET_l,
    nm_host_sequencer_if.master bus,
    output logic [2:0]          dbg_state_o
);
    localparam int TW = $clog2(TIMEOUT) + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0] OP_LEARN  = 2'd0;
    localparam logic [1:0] OP_RECOG  = 2'd1;
    localparam logic [1:0] OP_FORGET = 2'd2;
    localparam logic [1:0] OP_RSVD   = 2'd3;

    localparam logic [3:0] REG_COMP   = 4'h1;
    localparam logic [3:0] REG_LCOMP  = 4'h2;
    localparam logic [3:0] REG_DIST   = 4'h3;
    localparam logic [3:0] REG_CAT    = 4'h4;
    localparam logic [3:0] REG_NID    = 4'hA;
    localparam logic [3:0] REG_FORGET = 4'hF;

    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
    localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT - 1);

    logic [2:0]       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [14:0]      cat_q, cat_d;
    logic [LEN_W-1:0] comp_cnt_q, comp_cnt_d;
    logic [1:0]       tail_q, tail_d;
    logic [TW-1:0]    wait_cnt_q, wait_cnt_d;
    logic             res_err_q, res_err_d;
    logic [15:0]      res_dist_q, res_dist_d;
    logic [15:0]      res_cat_q, res_cat_d;
    logic [15:0]      res_nid_q, res_nid_d;

    logic             comp_phase;
    logic [3:0]       cur_reg;
    logic             cur_write;
    logic [15:0]      cur_wdata;
    logic             last_access;
    logic             strobe;
    logic             cmd_bad;

    // The current access is derived from the progress counters: components
    // first, then the command-specific tail (CAT write, or DIST/CAT/NID reads).
    always_comb begin
        comp_phase  = 1'b0;
        cur_reg     = REG_FORGET;
        cur_write   = 1'b1;
        cur_wdata   = 16'h0000;
        last_access = 1'b1;
        if (op_q == OP_FORGET) begin
            cur_reg = REG_FORGET;
        end else if (comp_cnt_q < len_q) begin
            comp_phase  = 1'b1;
            cur_reg     = (comp_cnt_q == len_q - LEN_ONE) ? REG_LCOMP : REG_COMP;
            cur_wdata   = {8'h00, bus.comp_data};
            last_access = 1'b0;
        end else if (op_q == OP_LEARN) begin
            cur_reg   = REG_CAT;
            cur_wdata = {1'b0, cat_q};
        end else begin
            cur_write = 1'b0;
            case (tail_q)
                2'd0: begin cur_reg = REG_DIST; last_access = 1'b0; end
                2'd1: begin cur_reg = REG_CAT;  last_access = 1'b0; end
                default: begin cur_reg = REG_NID; last_access = 1'b1; end
            endcase
        end
    end

    assign strobe  = (state_q == S_ISSUE) && (!comp_phase || bus.comp_valid);
    assign cmd_bad = (bus.cmd_len == '0) || (bus.cmd_len > LEN_MAX) || (bus.cmd_op == OP_RSVD);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        len_d      = len_q;
        cat_d      = cat_q;
        comp_cnt_d = comp_cnt_q;
        tail_d     = tail_q;
        wait_cnt_d = wait_cnt_q;
        res_err_d  = res_err_q;
        res_dist_d = res_dist_q;
        res_cat_d  = res_cat_q;
        res_nid_d  = res_nid_q;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    op_d       = bus.cmd_op;
                    len_d      = bus.cmd_len;
                    cat_d      = bus.cmd_cat;
                    comp_cnt_d = '0;
                    tail_d     = 2'd0;
                    res_err_d  = cmd_bad;
                    state_d    = cmd_bad ? S_DONE : S_SETUP;
                end
            end
            S_SETUP: state_d = S_ISSUE;
            S_ISSUE: begin
                if (strobe) begin
                    wait_cnt_d = '0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.nm_rdy) begin
                    if (!cur_write) begin
                        case (cur_reg)
                            REG_DIST: res_dist_d = bus.nm_rdata;
                            REG_CAT:  res_cat_d  = bus.nm_rdata;
                            REG_NID:  res_nid_d  = bus.nm_rdata;
                            default:  ;
                        endcase
                    end
                    if (comp_phase) comp_cnt_d = comp_cnt_q + LEN_ONE;
                    else            tail_d     = tail_q + 2'd1;
                    res_err_d = 1'b0;
                    state_d   = last_access ? S_DONE : S_ISSUE;
                end else if (wait_cnt_q == TMO_LAST) begin
                    res_err_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + TW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge G_CLK or negedge G_RESET_l) begin
        if (!G_RESET_l) begin
            state_q    <= S_IDLE;
            op_q       <= OP_LEARN;
            len_q      <= '0;
            cat_q      <= '0;
            comp_cnt_q <= '0;
            tail_q     <= 2'd0;
            wait_cnt_q <= '0;
            res_err_q  <= 1'b0;
            res_dist_q <= 16'h0000;
            res_cat_q  <= 16'h0000;
            res_nid_q  <= 16'h0000;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            len_q      <= len_d;
            cat_q      <= cat_d;
            comp_cnt_q <= comp_cnt_d;
            tail_q     <= tail_d;
            wait_cnt_q <= wait_cnt_d;
            res_err_q  <= res_err_d;
            res_dist_q <= res_dist_d;
            res_cat_q  <= res_cat_d;
            res_nid_q  <= res_nid_d;
        end
    end

    // Bus outputs decode straight from state so an asynchronous reset clears them at once.
    assign bus.cmd_ready  = (state_q == S_IDLE) && G_RESET_l;
    assign bus.comp_ready = strobe && comp_phase;
    assign bus.res_valid  = (state_q == S_DONE);
    assign bus.res_err    = res_err_q;
    assign bus.res_dist   = res_dist_q;
    assign bus.res_cat    = res_cat_q;
    assign bus.res_nid    = res_nid_q;

    assign bus.nm_cs_l    = !((state_q == S_SETUP) || (state_q == S_ISSUE) || (state_q == S_WAIT));
    assign bus.nm_ds      = strobe;
    assign bus.nm_rw_l    = (state_q == S_ISSUE) ? !cur_write : 1'b1;
    assign bus.nm_reg     = (state_q == S_ISSUE) ? cur_reg : 4'h0;
    assign bus.nm_wdata   = (state_q == S_ISSUE && cur_write) ? cur_wdata : 16'h0000;
    assign bus.nm_data_oe = (state_q == S_ISSUE) && cur_write;

    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_nm_host_sequencer.sv
// Directed bench for nm_host_sequencer: small network model, component feeder,
// bus monitor with an expected-access queue, and immediate-assertion checks.
module tb_nm_host_sequencer;
    localparam int LEN_W = 9;

    logic       clk;
    logic       rst_n;
    logic [2:0] dbg_state;

    nm_host_sequencer_if #(.LEN_W(LEN_W)) bus ();

    nm_host_sequencer #(.MAX_LEN(256), .TIMEOUT(16)) dut (
        .G_CLK       (clk),
        .G_RESET_l   (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Access record: {rw_l, reg[3:0], wdata[15:0]}, wdata zeroed for reads.
    logic [20:0] exp_q[$];
    logic [20:0] obs_q[$];
    int          ds_cnt;
    int          cs_low_cnt;
    int          viol;
    logic        prev_ds;

    logic [7:0]  comp_src[$];
    logic [7:0]  popped;
    bit          consume_pending;
    bit          gap_arm;
    int          gap_left;
    bit          rdy_low;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Network model: ready unless held low; read data keyed by register.
    assign bus.nm_rdy = !rdy_low;
    always @(negedge clk) begin
        if (bus.nm_ds && bus.nm_rw_l) begin
            case (bus.nm_reg)
                4'h3:    bus.nm_rdata = 16'h0012;
                4'h4:    bus.nm_rdata = 16'h0005;
                4'hA:    bus.nm_rdata = 16'h0003;
                default: bus.nm_rdata = 16'hDEAD;
            endcase
        end
    end

    // Bus monitor.
    always @(negedge clk) begin
        if (bus.nm_ds) begin
            obs_q.push_back({bus.nm_rw_l, bus.nm_reg, bus.nm_rw_l ? 16'h0000 : bus.nm_wdata});
            ds_cnt++;
            if (prev_ds) viol++;
            if (bus.nm_data_oe !== !bus.nm_rw_l) viol++;
            if (bus.nm_cs_l) viol++;
        end
        if ((bus.nm_ds || bus.comp_ready) && bus.nm_rw_l == 1'b0 && bus.nm_reg inside {4'h1, 4'h2}
            && !bus.comp_valid) viol++;
        if (bus.comp_ready && !bus.comp_valid) viol++;
        if (!bus.nm_cs_l) cs_low_cnt++;
        prev_ds = bus.nm_ds;
        consume_pending = bus.comp_valid && bus.comp_ready;
    end

    // Component feeder: pops on consumption, optional 5-cycle gap after the first.
    always @(posedge clk) begin
        #1;
        if (consume_pending && comp_src.size() > 0) begin
            popped = comp_src.pop_front();
            if (gap_arm) begin
                gap_left = 5;
                gap_arm  = 1'b0;
            end
        end
        consume_pending = 1'b0;
        if (comp_src.size() > 0 && gap_left == 0) begin
            bus.comp_valid = 1'b1;
            bus.comp_data  = comp_src[0];
        end else begin
            bus.comp_valid = 1'b0;
            bus.comp_data  = 8'h00;
        end
        if (gap_left > 0) gap_left--;
    end

    task automatic clear_mon();
        obs_q.delete();
        exp_q.delete();
        ds_cnt     = 0;
        cs_low_cnt = 0;
        viol       = 0;
    endtask

    task automatic start_cmd(input logic [1:0] op, input logic [LEN_W-1:0] len, input logic [14:0] cat);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_len   = len;
        bus.cmd_cat   = cat;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output logic err);
        cyc = -1;
        err = 1'bx;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (bus.res_valid) begin
                cyc = i;
                err = bus.res_err;
                break;
            end
        end
    endtask

    task automatic check_bus(input string tag);
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check($sformatf("%s_acc%0d", tag, i), {11'h0, obs_q[i]}, {11'h0, exp_q[i]});
    endtask

    int   cyc;
    logic err;

    initial begin
        rst_n          = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = 2'd0;
        bus.cmd_len    = '0;
        bus.cmd_cat    = '0;
        bus.comp_valid = 1'b0;
        bus.comp_data  = 8'h00;
        bus.nm_rdata   = 16'h0000;
        rdy_low        = 1'b0;
        gap_arm        = 1'b0;
        gap_left       = 0;
        prev_ds        = 1'b0;
        clear_mon();

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_cs_l", bus.nm_cs_l, 1);
        check("rst_ds", bus.nm_ds, 0);
        check("rst_rw_l", bus.nm_rw_l, 1);
        check("rst_reg", bus.nm_reg, 0);
        check("rst_wdata", bus.nm_wdata, 0);
        check("rst_oe", bus.nm_data_oe, 0);
        check("rst_comp_ready", bus.comp_ready, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_err", bus.res_err, 0);
        check("rst_res_dist", bus.res_dist, 0);
        check("rst_cmd_ready_in_reset", bus.cmd_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", bus.cmd_ready, 1);

        // LEARN len=3 cat=5.
        clear_mon();
        comp_src = '{8'h10, 8'h20, 8'h30};
        exp_q = '{{1'b0, 4'h1, 16'h0010}, {1'b0, 4'h1, 16'h0020},
                  {1'b0, 4'h2, 16'h0030}, {1'b0, 4'h4, 16'h0005}};
        start_cmd(2'd0, 9'd3, 15'd5);
        check("learn_busy_cmd_ready", bus.cmd_ready, 0);
        wait_done(cyc, err);
        check("learn_cycles", cyc, 10);
        check("learn_err", err, 0);
        check("learn_done_cs_l", bus.nm_cs_l, 1);
        @(negedge clk);
        check("learn_cmd_ready_back", bus.cmd_ready, 1);
        check_bus("learn_bus");
        check("learn_viol", viol, 0);

        // RECOGNIZE len=1.
        clear_mon();
        comp_src = '{8'h7F};
        exp_q = '{{1'b0, 4'h2, 16'h007F}, {1'b1, 4'h3, 16'h0000},
                  {1'b1, 4'h4, 16'h0000}, {1'b1, 4'hA, 16'h0000}};
        start_cmd(2'd1, 9'd1, 15'd0);
        wait_done(cyc, err);
        check("recog_cycles", cyc, 10);
        check("recog_err", err, 0);
        check("recog_dist", bus.res_dist, 16'h0012);
        check("recog_cat", bus.res_cat, 16'h0005);
        check("recog_nid", bus.res_nid, 16'h0003);
        check_bus("recog_bus");

        // LEARN len=2 with a 5-cycle component gap; results must hold.
        @(negedge clk);
        clear_mon();
        gap_arm  = 1'b1;
        comp_src = '{8'hA1, 8'hA2};
        exp_q = '{{1'b0, 4'h1, 16'h00A1}, {1'b0, 4'h2, 16'h00A2}, {1'b0, 4'h4, 16'h0009}};
        start_cmd(2'd0, 9'd2, 15'd9);
        wait_done(cyc, err);
        check("gap_cycles", cyc, 12);
        check("gap_err", err, 0);
        check_bus("gap_bus");
        check("gap_viol", viol, 0);
        check("gap_dist_hold", bus.res_dist, 16'h0012);
        check("gap_nid_hold", bus.res_nid, 16'h0003);

        // Timeout: rdy held low after the first DS.
        @(negedge clk);
        clear_mon();
        rdy_low  = 1'b1;
        comp_src = '{8'h01, 8'h02};
        exp_q = '{{1'b0, 4'h1, 16'h0001}};
        start_cmd(2'd0, 9'd2, 15'd7);
        wait_done(cyc, err);
        check("tmo_cycles", cyc, 19);
        check("tmo_err", err, 1);
        repeat (3) @(negedge clk);
        check("tmo_ds_count", ds_cnt, 1);
        check("tmo_cs_l_after", bus.nm_cs_l, 1);
        check_bus("tmo_bus");
        rdy_low = 1'b0;
        comp_src.delete();
        @(negedge clk);

        // Rejected commands: len 0, op 3, len above MAX_LEN.
        for (int k = 0; k < 3; k++) begin
            clear_mon();
            case (k)
                0: start_cmd(2'd0, 9'd0, 15'd1);
                1: start_cmd(2'd3, 9'd2, 15'd1);
                default: start_cmd(2'd1, 9'd300, 15'd1);
            endcase
            wait_done(cyc, err);
            check($sformatf("bad%0d_cycles", k), cyc, 1);
            check($sformatf("bad%0d_err", k), err, 1);
            check($sformatf("bad%0d_ds", k), ds_cnt, 0);
            check($sformatf("bad%0d_cs", k), cs_low_cnt, 0);
        end

        // Reset during the second COMP of a len=4 LEARN.
        clear_mon();
        comp_src = '{8'h11, 8'h22, 8'h33, 8'h44};
        start_cmd(2'd0, 9'd4, 15'd2);
        for (int i = 0; i < 50 && ds_cnt < 2; i++) @(negedge clk);
        check("rst_mid_second_ds", ds_cnt, 2);
        #1 rst_n = 1'b0;
        #1;
        check("rstm_cs_l", bus.nm_cs_l, 1);
        check("rstm_ds", bus.nm_ds, 0);
        check("rstm_rw_l", bus.nm_rw_l, 1);
        check("rstm_reg", bus.nm_reg, 0);
        check("rstm_wdata", bus.nm_wdata, 0);
        check("rstm_oe", bus.nm_data_oe, 0);
        check("rstm_comp_ready", bus.comp_ready, 0);
        check("rstm_res_dist", bus.res_dist, 0);
        check("rstm_res_cat", bus.res_cat, 0);
        repeat (2) @(negedge clk);
        comp_src.delete();
        rst_n = 1'b1;
        @(negedge clk);
        clear_mon();
        exp_q = '{{1'b0, 4'hF, 16'h0000}};
        start_cmd(2'd2, 9'd1, 15'd0);
        wait_done(cyc, err);
        check("forget_cycles", cyc, 4);
        check("forget_err", err, 0);
        check_bus("forget_bus");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/nm_host_sequencer.md
# nm_host_sequencer

Bus master that drives the neuron-network register interface (CS_l/DS/RW_l/REG/DATA/RDY) on behalf of a single command requester. It turns one command (LEARN, RECOGNIZE, FORGET) plus a stream of 8-bit vector components into the exact sequence of register writes and reads the network needs. It returns distance, category and neuron ID for recognition. It sits between the system-side logic and the network top, and is the only master on the network bus.

## Interface
- MAX_LEN, 256: maximum vector length in components; LEN_W = clog2(MAX_LEN)+1.
- TIMEOUT, 4096: maximum number of cycles to wait for RDY per access before aborting.
- G_CLK  in  1  clock; same clock as the network.
- G_RESET_l  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  command: 0=LEARN, 1=RECOGNIZE, 2=FORGET, 3=reserved.
- cmd_len  in  LEN_W  vector length in components.
- cmd_cat  in  15  category for LEARN.
- comp_valid  in  1  component available.
- comp_ready  out  1  component accepted.
- comp_data  in  8  component value.
- res_valid  out  1  one-cycle pulse at command completion.
- res_err  out  1  qualifies res_valid; set on an error.
- res_dist  out  16  DIST read (RECOGNIZE only).
- res_cat  out  16  CAT read (RECOGNIZE only).
- res_nid  out  16  NID read (RECOGNIZE only).
- nm_cs_l  out  1  network chip select, active-low.
- nm_ds  out  1  data strobe.
- nm_rw_l  out  1  1=read, 0=write.
- nm_reg  out  4  register address.
- nm_wdata  out  16  write data.
- nm_data_oe  out  1  drive enable for DATA pads (write accesses only).
- nm_rdata  in  16  DATA pads as seen at the input.
- nm_rdy  in  1  network ready.

## Operation
- Register map: COMP=0x1, LCOMP=0x2, DIST=0x3, CAT=0x4, NID=0xA, FORGET=0xF.
- FSM states: IDLE, SETUP, ISSUE, WAIT, DONE.
- Command acceptance:
  - A command is accepted when cmd_valid & cmd_ready; op, len and cat are latched.
  - cmd_len==0, cmd_len>MAX_LEN, or op==3: no bus activity. Go IDLE->DONE with res_err=1.
- Access lists:
  - LEARN: COMP writes for components 0..len-2, then LCOMP for the last component, then a CAT write with {1'b0,cmd_cat}.
  - RECOGNIZE: the same COMP/LCOMP writes, then reads of DIST, CAT and NID, in that order.
  - FORGET: a single write to FORGET with data 0.
  - len==1: only the LCOMP write.
- SETUP: nm_cs_l goes low; held for exactly 1 cycle before the first ISSUE, because the network registers CS_l as standby.
- ISSUE: nm_ds=1 for exactly one cycle. nm_reg, nm_rw_l and nm_wdata are valid in the same cycle. nm_data_oe = ~nm_rw_l.
- Component writes:
  - ISSUE for a COMP/LCOMP write waits in ISSUE with nm_ds=0 until comp_valid.
  - comp_ready=1 in the cycle DS is asserted, so consumption and strobe coincide.
  - nm_wdata = {8'h00, comp_data}.
- WAIT:
  - From the cycle after DS, count cycles until nm_rdy=1.
  - For a read access, latch nm_rdata into the matching res_* register in the cycle nm_rdy=1 is sampled.
  - Then go to ISSUE for the next access, or to DONE after the last one.
- Timeout: if the WAIT count reaches TIMEOUT, abort to DONE with res_err=1. No further accesses are issued.
- DONE: res_valid=1 for one cycle, nm_cs_l returns high, then go to IDLE.
- Result registers: the res_* values hold until the next RECOGNIZE completes. LEARN and FORGET do not modify them.
- Outputs outside ISSUE: nm_ds=0 and nm_data_oe=0; nm_cs_l=1 in IDLE.

## Timing
- Reset values:
  - State IDLE; cmd_ready=1 (while G_RESET_l high); comp_ready=0.
  - res_valid=0, res_err=0, res_dist/cat/nid=0.
  - nm_cs_l=1, nm_ds=0, nm_rw_l=1, nm_reg=0, nm_wdata=0, nm_data_oe=0.
- Reset mid-command: all outputs return to reset values immediately. The partially written vector is abandoned and the next command restarts cleanly.
- Per access: 1 ISSUE cycle + N WAIT cycles (N>=1, the first cycle where nm_rdy=1).
- Command length with RDY always high and components always valid: 1 (SETUP) + 2*accesses + 1 (DONE).
  - LEARN len L: 2L+4 cycles from acceptance to res_valid.
  - RECOGNIZE len L: 2L+8 cycles.
- cmd_valid during a busy command is ignored (cmd_ready=0). cmd_ready returns the cycle after DONE.
- nm_rdy low at command start (e.g. the network is still in its 256-cycle reset): the first access still issues. WAIT absorbs the delay, subject to TIMEOUT.

## Test plan
- LEARN, len=3, cat=5, rdy tied 1, comps 0x10,0x20,0x30:
  - Bus shows COMP 0x0010, COMP 0x0020, LCOMP 0x0030, CAT 0x0005, each with DS one cycle.
  - res_valid at cycle 10 after acceptance, res_err=0.
- RECOGNIZE, len=1, comp 0x7F; rdata returns 0x0012, 0x0005, 0x0003 on the three reads:
  - Writes LCOMP 0x007F, then reads reg 3, 4, 0xA.
  - res_dist=0x0012, res_cat=0x0005, res_nid=0x0003, res_err=0.
- comp_valid low for 5 cycles before the second component:
  - nm_ds stays 0 and comp_ready stays 0 until valid.
  - No duplicate or skipped components.
- nm_rdy held low after a DS, TIMEOUT=16:
  - res_valid with res_err=1 exactly 16 WAIT cycles after the DS.
  - No further DS; nm_cs_l high afterwards.
- cmd_len=0 and cmd_op=3:
  - No DS and nm_cs_l stays 1.
  - res_valid with res_err=1 one cycle after acceptance.
- G_RESET_l asserted during the second COMP of a len=4 LEARN:
  - Outputs go to reset values asynchronously.
  - A following FORGET performs a single write reg 0xF, data 0x0000.
